// File: rtl/xip_pkg.sv
// xip_pkg: shared line geometry, prefetcher state encoding and line-address helpers
package xip_pkg;

    localparam int LINE_SIZE  = 128;
    localparam int ADDR_W     = 24;
    localparam int LINE_BYTES = LINE_SIZE / 8;
    localparam int OFS_W      = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEMAND   = 3'd1,
        PREFETCH = 3'd2,
        PF_CLAIM = 3'd3,
        PF_DRAIN = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    endfunction

    // Wraps modulo the flash address space, so the last line is followed by line 0.
    function automatic logic [ADDR_W-1:0] line_nxt(input logic [ADDR_W-1:0] a);
        return line_of(a) + ADDR_W'(LINE_BYTES);
    endfunction

endpackage

// File: rtl/xip_line_prefetcher.sv
// xip_line_prefetcher: serves XIP cache misses from flash and keeps the next sequential line
// in a one-line buffer so straight-line code misses complete in one cycle.
module xip_line_prefetcher
    import xip_pkg::*;
#(
    parameter bit PF_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_rd,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 req_done,
    output logic [LINE_SIZE-1:0] req_line,
    input  logic                 inv,
    output logic                 pf_hit,
    output logic                 fr_rd,
    output logic [ADDR_W-1:0]    fr_addr,
    input  logic                 fr_done,
    input  logic [LINE_SIZE-1:0] fr_line
);

    state_t                 state;
    logic                   done_q;
    logic                   rise;
    logic                   pf_valid;
    logic                   pf_kill;
    logic [LINE_SIZE-1:0]   pf_data;
    logic [ADDR_W-1:0]      pf_addr;
    logic [ADDR_W-1:0]      dr_addr;
    logic [ADDR_W-1:0]      req_la;
    logic                   buf_hit;
    logic                   fly_hit;

    assign rise    = fr_done & ~done_q;
    assign req_la  = line_of(req_addr);
    // inv in the same cycle as a request wins, so neither hit form may fire then
    assign buf_hit = req_rd & ~inv & pf_valid & (req_la == pf_addr);
    assign fly_hit = req_rd & ~inv & ~pf_kill & (req_la == fr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            pf_valid <= 1'b0;
            pf_kill  <= 1'b0;
            pf_data  <= '0;
            pf_addr  <= '0;
            dr_addr  <= '0;
            req_done <= 1'b0;
            req_line <= '0;
            pf_hit   <= 1'b0;
            fr_rd    <= 1'b0;
            fr_addr  <= '0;
        end else begin
            done_q   <= fr_done;
            fr_rd    <= 1'b0;
            req_done <= 1'b0;
            pf_hit   <= 1'b0;
            if (inv) pf_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_rd) begin
                        pf_valid <= 1'b0;
                        if (buf_hit) begin
                            req_done <= 1'b1;
                            pf_hit   <= 1'b1;
                            req_line <= pf_data;
                            if (PF_EN) begin
                                fr_rd   <= 1'b1;
                                fr_addr <= line_nxt(req_addr);
                                state   <= PREFETCH;
                            end
                        end else begin
                            fr_rd   <= 1'b1;
                            fr_addr <= req_la;
                            state   <= DEMAND;
                        end
                    end
                end
                DEMAND, PF_CLAIM: begin
                    if (rise) begin
                        req_line <= fr_line;
                        req_done <= 1'b1;
                        if (PF_EN) begin
                            fr_rd   <= 1'b1;
                            fr_addr <= line_nxt(fr_addr);
                            state   <= PREFETCH;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                PREFETCH: begin
                    if (rise && req_rd) begin
                        // the landing line is treated as already buffered, then the request is judged
                        pf_valid <= 1'b0;
                        pf_kill  <= 1'b0;
                        fr_rd    <= 1'b1;
                        if (fly_hit) begin
                            req_done <= 1'b1;
                            pf_hit   <= 1'b1;
                            req_line <= fr_line;
                            fr_addr  <= line_nxt(fr_addr);
                        end else begin
                            fr_addr  <= req_la;
                            state    <= DEMAND;
                        end
                    end else if (rise) begin
                        pf_data  <= fr_line;
                        pf_addr  <= fr_addr;
                        pf_valid <= ~pf_kill & ~inv;
                        pf_kill  <= 1'b0;
                        state    <= IDLE;
                    end else if (req_rd) begin
                        pf_kill <= 1'b0;
                        if (fly_hit) begin
                            pf_hit <= 1'b1;
                            state  <= PF_CLAIM;
                        end else begin
                            dr_addr <= req_la;
                            state   <= PF_DRAIN;
                        end
                    end else if (inv) begin
                        pf_kill <= 1'b1;
                    end
                end
                PF_DRAIN: begin
                    if (rise) begin
                        fr_rd   <= 1'b1;
                        fr_addr <= dr_addr;
                        state   <= DEMAND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xip_line_prefetcher.sv
// tb_xip_line_prefetcher: scoreboard bench with a behavioural flash reader for the
// prefetching instance and directed pass-through checks for a PF_EN=0 instance.
module tb_xip_line_prefetcher;
    import xip_pkg::*;

    typedef struct {
        logic [127:0] line;
        logic         hit;
        logic         rd;
        logic         by_req;
        int           at;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_rd = 1'b0, inv = 1'b0, fr_done = 1'b0;
    logic [23:0]  req_addr = '0;
    logic [127:0] fr_line = '0;
    logic         req_done, pf_hit, fr_rd;
    logic [127:0] req_line;
    logic [23:0]  fr_addr;

    logic         q_req_rd = 1'b0, q_fr_done = 1'b0;
    logic [23:0]  q_req_addr = '0;
    logic [127:0] q_fr_line = '0;
    logic         q_req_done, q_pf_hit, q_fr_rd;
    logic [127:0] q_req_line;
    logic [23:0]  q_fr_addr;

    int tests = 0, fails = 0, cyc = 0, rise_cyc = 0;
    int rd_delay = 52, rd_hold = 1, hit_exp = 0, hit_seen = 0;
    done_t       exp_done[$];
    done_t       e_m;
    logic [23:0] exp_rd[$];
    logic        busy = 1'b0;
    int          lat = 0, hold = 0;
    logic [23:0] rd_a = '0;

    xip_line_prefetcher #(.PF_EN(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_addr(req_addr),
        .req_done(req_done), .req_line(req_line), .inv(inv), .pf_hit(pf_hit),
        .fr_rd(fr_rd), .fr_addr(fr_addr), .fr_done(fr_done), .fr_line(fr_line)
    );

    xip_line_prefetcher #(.PF_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .req_rd(q_req_rd), .req_addr(q_req_addr),
        .req_done(q_req_done), .req_line(q_req_line), .inv(1'b0), .pf_hit(q_pf_hit),
        .fr_rd(q_fr_rd), .fr_addr(q_fr_addr), .fr_done(q_fr_done), .fr_line(q_fr_line)
    );

    function automatic logic [127:0] dat(input logic [23:0] a);
        return {8'hC0, a, 8'h11, ~a, 8'h22, a ^ 24'h5A5A5A, 32'hFEED0000 ^ {8'h00, a}};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // flash reader: one read at a time, done after rd_delay cycles, held rd_hold cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) fr_done = 1'b0;
                end
                if (fr_rd) begin
                    check("one_outstanding", busy, 1'b0);
                    busy = 1'b1;
                    lat  = rd_delay;
                    rd_a = fr_addr;
                end else if (busy) begin
                    lat--;
                    if (lat == 0) begin
                        check("fr_addr_stable", fr_addr, rd_a);
                        fr_line  = dat(rd_a);
                        fr_done  = 1'b1;
                        hold     = rd_hold;
                        busy     = 1'b0;
                        rise_cyc = cyc;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_done) begin
                if (exp_done.size() == 0) check("unexpected_req_done", 1'b1, 1'b0);
                else begin
                    e_m = exp_done.pop_front();
                    check("req_line", req_line, e_m.line);
                    check("pf_hit_with_done", pf_hit, e_m.hit);
                    check("fr_rd_with_done", fr_rd, e_m.rd);
                    check("done_cycle", cyc, e_m.by_req ? e_m.at : rise_cyc + 1);
                end
            end else if (pf_hit) begin
                check("claim_pf_hit", hit_seen < hit_exp, 1'b1);
                hit_seen++;
            end
            if (fr_rd) begin
                if (exp_rd.size() == 0) check("unexpected_fr_rd", 1'b1, 1'b0);
                else check("fr_addr", fr_addr, exp_rd.pop_front());
            end
        end
    end

    task automatic do_req(input logic [23:0] a, input logic with_inv);
        @(posedge clk); #1;
        req_rd = 1'b1; req_addr = a; inv = with_inv;
        @(posedge clk); #1;
        req_rd = 1'b0; inv = 1'b0;
    endtask

    task automatic push_miss(input logic [23:0] a);
        exp_rd.push_back(line_of(a));
        exp_rd.push_back(line_nxt(a));
        exp_done.push_back('{dat(line_of(a)), 1'b0, 1'b1, 1'b0, 0});
    endtask

    task automatic settle();
        int n = 0;
        repeat (3) @(posedge clk);
        while ((busy || fr_done || exp_done.size() != 0 || exp_rd.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("settle_in_time", n < 2000, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stray;
        repeat (3) @(posedge clk); #1;
        check("rst_req_done", req_done, 1'b0);
        check("rst_req_line", req_line, '0);
        check("rst_fr_rd", fr_rd, 1'b0);
        check("rst_fr_addr", fr_addr, '0);
        check("rst_pf_hit", pf_hit, 1'b0);
        check("rst_q_fr_rd", q_fr_rd, 1'b0);
        rst_n = 1'b1;

        do_req(24'h000120, 1'b0);
        push_miss(24'h000120);
        settle();

        rd_delay = 10;
        do_req(24'h00013C, 1'b0);
        exp_done.push_back('{dat(24'h000130), 1'b1, 1'b1, 1'b1, cyc});
        exp_rd.push_back(24'h000140);
        do_req(24'h000140, 1'b0);
        hit_exp++;
        exp_done.push_back('{dat(24'h000140), 1'b0, 1'b1, 1'b0, 0});
        exp_rd.push_back(24'h000150);
        settle();

        do_req(24'h000150, 1'b0);
        exp_done.push_back('{dat(24'h000150), 1'b1, 1'b1, 1'b1, cyc});
        exp_rd.push_back(24'h000160);
        do_req(24'h004000, 1'b0);
        push_miss(24'h004000);
        settle();

        do_req(24'hFFFFF0, 1'b0);
        push_miss(24'hFFFFF0);
        n = 0;
        while (exp_rd.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("wrap_prefetch_issued", n < 500, 1'b1);
        #1 inv = 1'b1;
        @(posedge clk); #1 inv = 1'b0;
        settle();
        do_req(24'h000000, 1'b0);
        push_miss(24'h000000);
        settle();

        rd_hold = 2;
        do_req(24'h000800, 1'b0);
        push_miss(24'h000800);
        settle();
        rd_hold = 1;

        do_req(24'h000814, 1'b1);
        push_miss(24'h000814);
        settle();

        check("done_queue_empty", exp_done.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("claim_count", hit_seen, hit_exp);

        @(posedge clk); #1;
        q_req_rd = 1'b1; q_req_addr = 24'h000208;
        @(posedge clk); #1;
        q_req_rd = 1'b0;
        check("nopf_fr_rd", q_fr_rd, 1'b1);
        check("nopf_fr_addr", q_fr_addr, 24'h000200);
        repeat (3) @(posedge clk); #1;
        check("nopf_fr_rd_pulse", q_fr_rd, 1'b0);
        q_fr_line = dat(24'h000200); q_fr_done = 1'b1;
        @(posedge clk); #1;
        check("nopf_req_done", q_req_done, 1'b1);
        check("nopf_req_line", q_req_line, dat(24'h000200));
        check("nopf_no_prefetch", q_fr_rd, 1'b0);
        check("nopf_no_hit", q_pf_hit, 1'b0);
        @(posedge clk); #1;
        q_fr_done = 1'b0;
        check("nopf_held_done_once", q_req_done, 1'b0);
        stray = 0;
        repeat (6) begin
            @(posedge clk); #1;
            stray += int'(q_fr_rd) + int'(q_req_done);
        end
        check("nopf_quiet", stray, 0);
        q_req_rd = 1'b1; q_req_addr = 24'h000210;
        @(posedge clk); #1;
        q_req_rd = 1'b0;
        check("nopf_next_misses", q_fr_rd, 1'b1);
        check("nopf_next_addr", q_fr_addr, 24'h000210);
        repeat (2) @(posedge clk); #1;
        q_fr_line = dat(24'h000210); q_fr_done = 1'b1;
        @(posedge clk); #1;
        check("nopf_req_line2", q_req_line, dat(24'h000210));
        q_fr_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
